// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core memory-port arbiter: FSM states, fetch access size
// and request bundles sized at the default 64-bit address/data widths.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   localparam logic [2:0] MSIZE4 = 3'b010;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } cbus_req_t;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Combinational grant pick between fetch and data requesters; zero latency.
// Default: data wins; with MEM_ARB_RR_EN a contended pick goes to the last loser.
module arb_select (
   input  logic i_ireq_vld,
   input  logic i_dreq_vld,
`ifdef MEM_ARB_RR_EN
   input  logic i_last_owner,
`endif
   output logic o_grant,
   output logic o_owner
);

   always_comb begin
      o_grant = i_ireq_vld | i_dreq_vld;
`ifdef MEM_ARB_RR_EN
      if (i_ireq_vld && i_dreq_vld) begin
         o_owner = ~i_last_owner;
      end else begin
         o_owner = i_dreq_vld;
      end
`else
      o_owner = i_dreq_vld;
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; grant 1 cycle after valid, >=2 cycles/txn.
// Requesters hold valid until granted; one transaction in flight; MEM_ARB_RR_EN enables round-robin.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ireq_valid,
   input  logic [ADDR_W-1:0] ireq_addr,
   output logic              iresp_addr_ok,
   output logic              iresp_data_ok,
   output logic [INST_W-1:0] iresp_data,
   input  logic              dreq_valid,
   input  logic [ADDR_W-1:0] dreq_addr,
   input  logic [2:0]        dreq_size,
   input  logic [7:0]        dreq_strobe,
   input  logic [DATA_W-1:0] dreq_data,
   output logic              dresp_addr_ok,
   output logic              dresp_data_ok,
   output logic [DATA_W-1:0] dresp_data,
   output logic              creq_valid,
   output logic              creq_is_write,
   output logic [ADDR_W-1:0] creq_addr,
   output logic [2:0]        creq_size,
   output logic [7:0]        creq_strobe,
   output logic [DATA_W-1:0] creq_data,
   input  logic              cresp_addr_ok,
   input  logic              cresp_data_ok,
   input  logic [DATA_W-1:0] cresp_data,
   output logic              busy,
   output logic              owner
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_owner;
   logic              r_is_write;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_size;
   logic [7:0]        r_strobe;
   logic [DATA_W-1:0] r_data;
   logic              w_grant;
   logic              w_sel_owner;
   logic              w_addr_ok;
   logic              w_data_ok;

`ifdef MEM_ARB_RR_EN
   logic              r_last_owner;
`endif

   arb_select u_arb_select (
      .i_ireq_vld   (ireq_valid),
      .i_dreq_vld   (dreq_valid),
`ifdef MEM_ARB_RR_EN
      .i_last_owner (r_last_owner),
`endif
      .o_grant      (w_grant),
      .o_owner      (w_sel_owner)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_addr_ok   = 1'b0;
      w_data_ok   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant) w_state_nxt = ADDR;
         end
         ADDR: begin
            if (cresp_addr_ok) begin
               w_addr_ok = 1'b1;
               if (cresp_data_ok) begin
                  w_data_ok   = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (cresp_data_ok) begin
               w_data_ok   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_owner    <= 1'b0;
         r_is_write <= 1'b0;
         r_addr     <= '0;
         r_size     <= '0;
         r_strobe   <= '0;
         r_data     <= '0;
`ifdef MEM_ARB_RR_EN
         r_last_owner <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_grant) begin
            r_owner <= w_sel_owner;
`ifdef MEM_ARB_RR_EN
            // Only contended picks move the pointer, so lone requests do not skew fairness.
            if (ireq_valid && dreq_valid) r_last_owner <= w_sel_owner;
`endif
            if (w_sel_owner) begin
               r_is_write <= |dreq_strobe;
               r_addr     <= dreq_addr;
               r_size     <= dreq_size;
               r_strobe   <= dreq_strobe;
               r_data     <= dreq_data;
            end else begin
               r_is_write <= 1'b0;
               r_addr     <= ireq_addr;
               r_size     <= MSIZE4;
               r_strobe   <= '0;
               r_data     <= '0;
            end
         end
      end
   end

   assign busy          = (r_state != IDLE);
   assign owner         = r_owner;
   assign creq_valid    = (r_state == ADDR);
   assign creq_is_write = r_is_write;
   assign creq_addr     = r_addr;
   assign creq_size     = r_size;
   assign creq_strobe   = r_strobe;
   assign creq_data     = r_data;

   assign iresp_addr_ok = w_addr_ok & ~r_owner;
   assign iresp_data_ok = w_data_ok & ~r_owner;
   assign dresp_addr_ok = w_addr_ok & r_owner;
   assign dresp_data_ok = w_data_ok & r_owner;

   // Fetch gets the 32-bit half of the beat selected by the latched word address.
   assign iresp_data = (busy && !r_owner) ?
                       (r_addr[2] ? cresp_data[2*INST_W-1:INST_W] : cresp_data[INST_W-1:0]) : '0;
   assign dresp_data = (busy && r_owner) ? cresp_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: responses are checked by a scoreboard monitor,
// request-side fields by inline checks.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok, iresp_data_ok;
   logic [31:0] iresp_data;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok, dresp_data_ok;
   logic [63:0] dresp_data;
   logic        creq_valid, creq_is_write;
   logic [63:0] creq_addr;
   logic [2:0]  creq_size;
   logic [7:0]  creq_strobe;
   logic [63:0] creq_data;
   logic        cresp_addr_ok, cresp_data_ok;
   logic [63:0] cresp_data;
   logic        busy, owner;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
      .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_data(creq_data),
      .cresp_addr_ok(cresp_addr_ok), .cresp_data_ok(cresp_data_ok), .cresp_data(cresp_data),
      .busy(busy), .owner(owner)
   );

   typedef struct {
      logic        is_d;
      logic [63:0] dat;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   // Response monitor: every data_ok must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (iresp_data_ok && dresp_data_ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL both_data_ok actual=11 required=one-hot");
         end else if (iresp_data_ok || dresp_data_ok) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_data_ok actual=i%0b/d%0b required=none",
                        iresp_data_ok, dresp_data_ok);
            end else begin
               e = sb_q.pop_front();
               chk("resp_port", {63'd0, dresp_data_ok}, {63'd0, e.is_d});
               chk("resp_data", dresp_data_ok ? dresp_data : {32'd0, iresp_data}, e.dat);
            end
         end
      end
   end

   task automatic push(input logic is_d, input logic [63:0] dat);
      exp_t e;
      e.is_d = is_d;
      e.dat  = dat;
      sb_q.push_back(e);
   endtask

   initial begin
      rst = 1'b0;
      ireq_valid = 0; ireq_addr = '0;
      dreq_valid = 0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
      cresp_addr_ok = 0; cresp_data_ok = 0; cresp_data = '0;
      nxt; nxt;
      mid;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_owner", {63'd0, owner}, 64'd0);
      chk("rst_creq_valid", {63'd0, creq_valid}, 64'd0);
      chk("rst_creq_fields", {creq_addr ^ creq_data, 53'd0, creq_is_write, creq_size, creq_strobe} == '0, 1);
      nxt;
      rst = 1'b1;

      // Fetch only, upper word
      ireq_valid = 1; ireq_addr = 64'h8000_0004;
      mid;
      chk("idle_no_passthru_vld", {63'd0, creq_valid}, 64'd0);
      chk("idle_no_passthru_busy", {63'd0, busy}, 64'd0);
      nxt;
      cresp_addr_ok = 1;
      mid;
      chk("f_busy", {63'd0, busy}, 64'd1);
      chk("f_owner", {63'd0, owner}, 64'd0);
      chk("f_creq_valid", {63'd0, creq_valid}, 64'd1);
      chk("f_creq_addr", creq_addr, 64'h8000_0004);
      chk("f_creq_size", {61'd0, creq_size}, 64'd2);
      chk("f_creq_strobe", {56'd0, creq_strobe}, 64'd0);
      chk("f_creq_is_write", {63'd0, creq_is_write}, 64'd0);
      chk("f_iresp_addr_ok", {63'd0, iresp_addr_ok}, 64'd1);
      chk("f_dresp_addr_ok", {63'd0, dresp_addr_ok}, 64'd0);
      nxt;
      cresp_addr_ok = 0;
      mid;
      chk("f_data_creq_valid", {63'd0, creq_valid}, 64'd0);
      chk("f_data_busy", {63'd0, busy}, 64'd1);
      nxt;
      push(0, 64'h0000_0000_DEAD_BEEF);
      cresp_data_ok = 1; cresp_data = 64'hDEAD_BEEF_1234_5678; ireq_valid = 0;
      mid;
      chk("f_iresp_data_ok", {63'd0, iresp_data_ok}, 64'd1);
      nxt;
      cresp_data_ok = 0; cresp_data = '0;
      mid;
      chk("f_busy_after", {63'd0, busy}, 64'd0);

      // Contention with combined handshake
      nxt;
      ireq_valid = 1; ireq_addr = 64'h8000_0010;
      dreq_valid = 1; dreq_addr = 64'h1000; dreq_size = 3; dreq_strobe = 0; dreq_data = '0;
      nxt;
      push(1, 64'hA5A5_5A5A_0F0F_F0F0);
      cresp_addr_ok = 1; cresp_data_ok = 1; cresp_data = 64'hA5A5_5A5A_0F0F_F0F0;
      mid;
      chk("c_owner_data", {63'd0, owner}, 64'd1);
      chk("c_creq_addr", creq_addr, 64'h1000);
      chk("c_creq_size", {61'd0, creq_size}, 64'd3);
      chk("c_dresp_addr_ok", {63'd0, dresp_addr_ok}, 64'd1);
      chk("c_dresp_data_ok", {63'd0, dresp_data_ok}, 64'd1);
      chk("c_iresp_addr_ok", {63'd0, iresp_addr_ok}, 64'd0);
      nxt;
      dreq_valid = 0; cresp_addr_ok = 0; cresp_data_ok = 0; cresp_data = '0;
      mid;
      chk("c_combined_to_idle", {63'd0, busy}, 64'd0);
      nxt;
      push(0, 64'h0000_0000_CAFE_BABE);
      cresp_addr_ok = 1; cresp_data_ok = 1; cresp_data = 64'h0BAD_F00D_CAFE_BABE;
      mid;
      chk("c_owner_fetch", {63'd0, owner}, 64'd0);
      chk("c_fetch_addr", creq_addr, 64'h8000_0010);
      chk("c_iresp_addr_ok", {63'd0, iresp_addr_ok}, 64'd1);
      nxt;
      ireq_valid = 0; cresp_addr_ok = 0; cresp_data_ok = 0; cresp_data = '0;

      // Write path; live inputs change after grant
      nxt;
      dreq_valid = 1; dreq_addr = 64'h2008; dreq_size = 2; dreq_strobe = 8'h0F;
      dreq_data = 64'h1122_3344;
      nxt;
      dreq_valid = 0; dreq_data = 64'hFFFF_FFFF; dreq_strobe = 8'hF0;
      cresp_addr_ok = 1;
      mid;
      chk("w_is_write", {63'd0, creq_is_write}, 64'd1);
      chk("w_addr", creq_addr, 64'h2008);
      chk("w_size", {61'd0, creq_size}, 64'd2);
      chk("w_strobe", {56'd0, creq_strobe}, 64'h0F);
      chk("w_data", creq_data, 64'h1122_3344);
      chk("w_dresp_addr_ok", {63'd0, dresp_addr_ok}, 64'd1);
      chk("w_iresp_quiet", {30'd0, iresp_addr_ok, iresp_data_ok, iresp_data}, 64'd0);
      nxt;
      cresp_addr_ok = 0;
      push(1, 64'h5555_0000_AAAA_0000);
      cresp_data_ok = 1; cresp_data = 64'h5555_0000_AAAA_0000;
      mid;
      chk("w_iresp_quiet2", {30'd0, iresp_addr_ok, iresp_data_ok, iresp_data}, 64'd0);
      nxt;
      cresp_data_ok = 0; cresp_data = '0;

      // Stray responses in IDLE
      cresp_addr_ok = 1; cresp_data_ok = 1; cresp_data = 64'h1234;
      mid;
      chk("stray_idle_oks", {60'd0, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 64'd0);
      nxt;
      cresp_addr_ok = 0; cresp_data_ok = 0; cresp_data = '0;
      mid;
      chk("stray_idle_busy", {63'd0, busy}, 64'd0);

      // Flush during DATA
      nxt;
      ireq_valid = 1; ireq_addr = 64'h8000_0008;
      nxt;
      cresp_addr_ok = 1;
      nxt;
      cresp_addr_ok = 0; ireq_valid = 0;
      mid;
      chk("fl_addr_held", creq_addr, 64'h8000_0008);
      chk("fl_size_held", {61'd0, creq_size}, 64'd2);
      chk("fl_busy", {63'd0, busy}, 64'd1);
      nxt;
      push(0, 64'h0000_0000_2222_2222);
      cresp_data_ok = 1; cresp_data = 64'h1111_1111_2222_2222;
      mid;
      chk("fl_iresp_data_ok", {63'd0, iresp_data_ok}, 64'd1);
      nxt;
      cresp_data_ok = 0; cresp_data = '0;
      mid;
      chk("fl_idle", {63'd0, busy}, 64'd0);

      // Async reset in DATA
      nxt;
      dreq_valid = 1; dreq_addr = 64'h3000; dreq_size = 3; dreq_strobe = 0;
      nxt;
      dreq_valid = 0; cresp_addr_ok = 1;
      nxt;
      cresp_addr_ok = 0;
      mid;
      chk("ar_pre_owner", {63'd0, owner}, 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_busy", {63'd0, busy}, 64'd0);
      chk("ar_owner", {63'd0, owner}, 64'd0);
      chk("ar_creq_valid", {63'd0, creq_valid}, 64'd0);
      chk("ar_creq_addr", creq_addr, 64'd0);
      nxt;
      cresp_data_ok = 1; cresp_data = 64'h9999;
      nxt;
      rst = 1'b1;
      mid;
      chk("ar_stray_ignored", {62'd0, iresp_data_ok, dresp_data_ok}, 64'd0);
      nxt;
      cresp_data_ok = 0; cresp_data = '0;
      mid;
      chk("ar_idle", {63'd0, busy}, 64'd0);

      nxt; nxt;
      mid;
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
